// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM beacon protocol: UM word flags, report word
// indices, message codes and the bit layout both ends of the link agree on.
package lcm_pkg;

  localparam logic [1:0] UM_HEAD = 2'b01;
  localparam logic [1:0] UM_MID  = 2'b11;
  localparam logic [1:0] UM_TAIL = 2'b10;

  localparam logic [2:0] W_ETH  = 3'd1;
  localparam logic [2:0] W_CFG  = 3'd2;
  localparam logic [2:0] W_ESW  = 3'd3;
  localparam logic [2:0] W_EOS  = 3'd4;
  localparam logic [2:0] W_GOE0 = 3'd5;
  localparam logic [2:0] W_GOE1 = 3'd6;
  localparam logic [2:0] W_LAST = 3'd7;

  localparam logic [15:0] LCM_ETH_TYPE = 16'h1662;
  localparam logic [7:0]  MSG_UPDATE   = 8'h01;
  localparam logic [7:0]  MSG_REPORT   = 8'h02;

  // w1 layout
  localparam int unsigned DMAC_LSB  = 80;
  localparam int unsigned ETYPE_LSB = 16;
  localparam int unsigned MTYPE_LSB = 8;
  localparam int unsigned LMID_LSB  = 0;
  // w2 layout
  localparam int unsigned DIR_BIT       = 127;
  localparam int unsigned TBKT_LSB      = 88;
  localparam int unsigned DIR_MAC_LSB   = 40;
  // w7 layout
  localparam int unsigned PTIME_LSB = 80;
  localparam int unsigned QUSED_LSB = 56;
  localparam int unsigned BUFM_LSB  = 48;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StDiscard,
    StWaitVld,
    StCommit
  } rx_state_e;

  typedef struct packed {
    logic [7:0]  lmid;
    logic        direction;
    logic [31:0] token_bucket_para;
    logic [47:0] direct_mac_addr;
    logic [63:0] esw_pktin_cnt;
    logic [63:0] esw_pktout_cnt;
    logic [63:0] eos_mdin_cnt;
    logic [63:0] eos_mdout_cnt;
    logic [63:0] goe_pktin_cnt;
    logic [63:0] goe_port0out_cnt;
    logic [63:0] goe_port1out_cnt;
    logic [63:0] goe_discard_cnt;
    logic [47:0] precision_time;
    logic [23:0] q_used_cnt;
    logic [7:0]  bufm_id_cnt;
  } lcm_rpt_t;

endpackage

// File: rtl/lcm_report_rx_if.sv
// UM packet stream into the report receiver: data/valid strobes plus ready.
interface lcm_report_rx_if;
  logic [133:0] in_data;
  logic         in_data_wr;
  logic         in_data_valid;
  logic         in_data_valid_wr;
  logic         pktin_ready;

  modport master (
    output in_data, in_data_wr, in_data_valid, in_data_valid_wr,
    input  pktin_ready
  );

  modport slave (
    input  in_data, in_data_wr, in_data_valid, in_data_valid_wr,
    output pktin_ready
  );
endinterface

// File: rtl/lcm_rpt_shadow.sv
// Shadow capture of report fields word by word, copied to the visible report
// bank in a single cycle on commit so consumers never see a partial report.
module lcm_rpt_shadow
  import lcm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_en,
  input  logic [2:0]   ld_idx,
  input  logic [127:0] word,
  input  logic         commit,
  output lcm_rpt_t     rpt
);

  lcm_rpt_t shadow_q, shadow_d, rpt_q;

  always_comb begin
    shadow_d = shadow_q;
    if (ld_en) begin
      case (ld_idx)
        W_ETH: shadow_d.lmid = word[LMID_LSB +: 8];
        W_CFG: begin
          shadow_d.direction         = word[DIR_BIT];
          shadow_d.token_bucket_para = word[TBKT_LSB +: 32];
          shadow_d.direct_mac_addr   = word[DIR_MAC_LSB +: 48];
        end
        W_ESW: begin
          shadow_d.esw_pktin_cnt  = word[127:64];
          shadow_d.esw_pktout_cnt = word[63:0];
        end
        W_EOS: begin
          shadow_d.eos_mdin_cnt  = word[127:64];
          shadow_d.eos_mdout_cnt = word[63:0];
        end
        W_GOE0: begin
          shadow_d.goe_pktin_cnt    = word[127:64];
          shadow_d.goe_port0out_cnt = word[63:0];
        end
        W_GOE1: begin
          shadow_d.goe_port1out_cnt = word[127:64];
          shadow_d.goe_discard_cnt  = word[63:0];
        end
        W_LAST: begin
          shadow_d.precision_time = word[PTIME_LSB +: 48];
          shadow_d.q_used_cnt     = word[QUSED_LSB +: 24];
          shadow_d.bufm_id_cnt    = word[BUFM_LSB +: 8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      rpt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (commit) rpt_q <= shadow_q;
    end
  end

  assign rpt = rpt_q;

endmodule

// File: rtl/lcm_report_rx.sv
// Beacon report receiver: filters UM frames by MAC/EtherType/type/LMID and
// commits the captured report atomically once the packet is confirmed good.
module lcm_report_rx
  import lcm_pkg::*;
#(
  parameter logic [15:0] ETH_TYPE = LCM_ETH_TYPE,
  parameter logic [7:0]  RPT_TYPE = MSG_REPORT,
  parameter logic [7:0]  LMID     = 8'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  lcm_report_rx_if.slave    um,
  input  logic [47:0]       in_local_mac_id,
  output logic [7:0]        rpt_lmid,
  output logic              rpt_direction,
  output logic [31:0]       rpt_token_bucket_para,
  output logic [47:0]       rpt_direct_mac_addr,
  output logic [63:0]       rpt_esw_pktin_cnt,
  output logic [63:0]       rpt_esw_pktout_cnt,
  output logic [63:0]       rpt_eos_mdin_cnt,
  output logic [63:0]       rpt_eos_mdout_cnt,
  output logic [63:0]       rpt_goe_pktin_cnt,
  output logic [63:0]       rpt_goe_port0out_cnt,
  output logic [63:0]       rpt_goe_port1out_cnt,
  output logic [63:0]       rpt_goe_discard_cnt,
  output logic [47:0]       rpt_precision_time,
  output logic [23:0]       rpt_q_used_cnt,
  output logic [7:0]        rpt_bufm_id_cnt,
  output logic              report_valid,
  output logic [31:0]       rx_ok_cnt,
  output logic [31:0]       rx_drop_cnt,
  output logic [31:0]       rx_err_cnt
);

  rx_state_e    state_q, state_d;
  logic [2:0]   wcnt_q, wcnt_d;
  logic         drop_q, drop_d;
  logic         len_ok_q, len_ok_d;
  logic         ready_q, ready_d;
  logic         rv_q;
  logic [31:0]  ok_q, drop_cnt_q, err_q;

  logic [1:0]   flag;
  logic [127:0] word;
  logic         is_head, is_tail, hdr_match;
  logic         tail_evt, resolve, err_inc, drop_inc, ld_en;
  logic [2:0]   ld_idx;
  logic         unused_ibc;
  lcm_rpt_t     rpt;

  assign flag       = um.in_data[133:132];
  assign word       = um.in_data[127:0];
  assign unused_ibc = ^um.in_data[131:128];
  assign is_head    = (flag == UM_HEAD);
  assign is_tail    = (flag == UM_TAIL);

  assign hdr_match = (word[DMAC_LSB +: 48] == in_local_mac_id) &&
                     (word[ETYPE_LSB +: 16] == ETH_TYPE) &&
                     (word[MTYPE_LSB +: 8] == RPT_TYPE) &&
                     ((LMID == 8'hFF) || (word[LMID_LSB +: 8] == LMID));

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    drop_d   = drop_q;
    len_ok_d = len_ok_q;
    tail_evt = 1'b0;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    ld_en    = 1'b0;
    ld_idx   = wcnt_q;

    case (state_q)
      StIdle: begin
        if (um.in_data_wr) begin
          if (is_head) begin
            state_d  = StHdr;
            drop_d   = 1'b0;
            len_ok_d = 1'b0;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      StHdr, StPayload, StDiscard: begin
        if (um.in_data_wr) begin
          if (is_head) begin
            // Missing tail: drop the old packet and parse the new head as w0
            err_inc  = 1'b1;
            state_d  = StHdr;
            drop_d   = 1'b0;
            len_ok_d = 1'b0;
          end else if (state_q == StHdr) begin
            ld_en  = 1'b1;
            ld_idx = W_ETH;
            drop_d = !hdr_match;
            if (is_tail) begin
              tail_evt = 1'b1;
              state_d  = StWaitVld;
            end else if (hdr_match) begin
              state_d = StPayload;
              wcnt_d  = W_CFG;
            end else begin
              state_d = StDiscard;
            end
          end else if (state_q == StPayload) begin
            ld_en = 1'b1;
            if (is_tail) begin
              tail_evt = 1'b1;
              len_ok_d = (wcnt_q == W_LAST);
              state_d  = StWaitVld;
            end else if (wcnt_q == W_LAST) begin
              state_d = StDiscard;
            end else begin
              wcnt_d = wcnt_q + 3'd1;
            end
          end else if (is_tail) begin
            tail_evt = 1'b1;
            state_d  = StWaitVld;
          end
        end
      end
      StCommit: state_d = StIdle;
      default: ;
    endcase

    // A valid strobe on the tail cycle resolves exactly as it would in WAIT_VLD
    resolve = um.in_data_valid_wr && ((state_q == StWaitVld) || tail_evt);
    if (resolve) begin
      if (drop_d) begin
        drop_inc = 1'b1;
        state_d  = StIdle;
      end else if (um.in_data_valid && len_ok_d) begin
        state_d = StCommit;
      end else begin
        err_inc = 1'b1;
        state_d = StIdle;
      end
    end

    ready_d = ((state_d == StIdle) || (state_d == StHdr) ||
               (state_d == StPayload) || (state_d == StDiscard)) && !(resolve && tail_evt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      drop_q     <= 1'b0;
      len_ok_q   <= 1'b0;
      ready_q    <= 1'b1;
      rv_q       <= 1'b0;
      ok_q       <= '0;
      drop_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      drop_q   <= drop_d;
      len_ok_q <= len_ok_d;
      ready_q  <= ready_d;
      rv_q     <= (state_q == StCommit);
      if (state_q == StCommit) ok_q <= ok_q + 32'd1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (err_inc) err_q <= err_q + 32'd1;
    end
  end

  lcm_rpt_shadow u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_en  (ld_en),
    .ld_idx (ld_idx),
    .word   (word),
    .commit (state_q == StCommit),
    .rpt    (rpt)
  );

  assign um.pktin_ready          = ready_q;
  assign report_valid            = rv_q;
  assign rx_ok_cnt               = ok_q;
  assign rx_drop_cnt             = drop_cnt_q;
  assign rx_err_cnt              = err_q;
  assign rpt_lmid                = rpt.lmid;
  assign rpt_direction           = rpt.direction;
  assign rpt_token_bucket_para   = rpt.token_bucket_para;
  assign rpt_direct_mac_addr     = rpt.direct_mac_addr;
  assign rpt_esw_pktin_cnt       = rpt.esw_pktin_cnt;
  assign rpt_esw_pktout_cnt      = rpt.esw_pktout_cnt;
  assign rpt_eos_mdin_cnt        = rpt.eos_mdin_cnt;
  assign rpt_eos_mdout_cnt       = rpt.eos_mdout_cnt;
  assign rpt_goe_pktin_cnt       = rpt.goe_pktin_cnt;
  assign rpt_goe_port0out_cnt    = rpt.goe_port0out_cnt;
  assign rpt_goe_port1out_cnt    = rpt.goe_port1out_cnt;
  assign rpt_goe_discard_cnt     = rpt.goe_discard_cnt;
  assign rpt_precision_time      = rpt.precision_time;
  assign rpt_q_used_cnt          = rpt.q_used_cnt;
  assign rpt_bufm_id_cnt         = rpt.bufm_id_cnt;

endmodule

// File: tb/tb_lcm_report_rx.sv
// Directed bench for lcm_report_rx: good, filtered, invalid, short, aborted,
// valid-on-tail and mid-packet-reset frames with hand-computed expectations.
module tb_lcm_report_rx;
  import lcm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] local_mac = 48'h001122334455;

  logic [7:0]  rpt_lmid;
  logic        rpt_direction;
  logic [31:0] rpt_token_bucket_para;
  logic [47:0] rpt_direct_mac_addr;
  logic [63:0] rpt_esw_pktin_cnt, rpt_esw_pktout_cnt, rpt_eos_mdin_cnt, rpt_eos_mdout_cnt;
  logic [63:0] rpt_goe_pktin_cnt, rpt_goe_port0out_cnt, rpt_goe_port1out_cnt;
  logic [63:0] rpt_goe_discard_cnt;
  logic [47:0] rpt_precision_time;
  logic [23:0] rpt_q_used_cnt;
  logic [7:0]  rpt_bufm_id_cnt;
  logic        report_valid;
  logic [31:0] rx_ok_cnt, rx_drop_cnt, rx_err_cnt;

  lcm_report_rx_if um ();

  lcm_report_rx #(
    .ETH_TYPE (16'h1662),
    .RPT_TYPE (8'h02),
    .LMID     (8'd1)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .um                    (um),
    .in_local_mac_id       (local_mac),
    .rpt_lmid              (rpt_lmid),
    .rpt_direction         (rpt_direction),
    .rpt_token_bucket_para (rpt_token_bucket_para),
    .rpt_direct_mac_addr   (rpt_direct_mac_addr),
    .rpt_esw_pktin_cnt     (rpt_esw_pktin_cnt),
    .rpt_esw_pktout_cnt    (rpt_esw_pktout_cnt),
    .rpt_eos_mdin_cnt      (rpt_eos_mdin_cnt),
    .rpt_eos_mdout_cnt     (rpt_eos_mdout_cnt),
    .rpt_goe_pktin_cnt     (rpt_goe_pktin_cnt),
    .rpt_goe_port0out_cnt  (rpt_goe_port0out_cnt),
    .rpt_goe_port1out_cnt  (rpt_goe_port1out_cnt),
    .rpt_goe_discard_cnt   (rpt_goe_discard_cnt),
    .rpt_precision_time    (rpt_precision_time),
    .rpt_q_used_cnt        (rpt_q_used_cnt),
    .rpt_bufm_id_cnt       (rpt_bufm_id_cnt),
    .report_valid          (report_valid),
    .rx_ok_cnt             (rx_ok_cnt),
    .rx_drop_cnt           (rx_drop_cnt),
    .rx_err_cnt            (rx_err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned vec_cnt = 0;
  int unsigned miss_cnt = 0;
  logic [127:0] fw [8];

  task automatic make_frame(input logic [47:0] dmac, input logic [15:0] etype,
                            input logic [63:0] esw_in, input logic [47:0] ptime);
    fw[0] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_0000;
    fw[1] = {dmac, 48'h0A0B0C0D0E0F, etype, 8'h02, 8'h01};
    fw[2] = {1'b1, 7'h55, 32'hCAFEBABE, 48'h665544332211, 40'hFF_FFFF_FFFF};
    fw[3] = {esw_in, 64'h0102030405060708};
    fw[4] = {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A};
    fw[5] = {64'h1000000000000001, 64'h2000000000000002};
    fw[6] = {64'h3000000000000003, 64'h4000000000000004};
    fw[7] = {ptime, 24'hABC123, 8'h77, 48'hFFFF_FFFF_FFFF};
  endtask

  task automatic send_words(input int first, input int last, input bit tail_last,
                            input bit valid_on_tail, input logic vld);
    logic [1:0] flg;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      if (i == 0) flg = UM_HEAD;
      else if (i == last && tail_last) flg = UM_TAIL;
      else flg = UM_MID;
      um.in_data          = {flg, 4'h0, fw[i]};
      um.in_data_wr       = 1'b1;
      um.in_data_valid_wr = (i == last) && valid_on_tail;
      um.in_data_valid    = vld;
    end
  endtask

  task automatic put_valid(input logic v);
    @(negedge clk);
    um.in_data_wr       = 1'b0;
    um.in_data_valid_wr = 1'b1;
    um.in_data_valid    = v;
  endtask

  task automatic quiet();
    @(negedge clk);
    um.in_data_wr       = 1'b0;
    um.in_data_valid_wr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({rpt_lmid, rpt_direction, rpt_token_bucket_para, rpt_direct_mac_addr,
         rpt_esw_pktin_cnt, rpt_esw_pktout_cnt, rpt_eos_mdin_cnt, rpt_eos_mdout_cnt,
         rpt_goe_pktin_cnt, rpt_goe_port0out_cnt, rpt_goe_port1out_cnt, rpt_goe_discard_cnt,
         rpt_precision_time, rpt_q_used_cnt, rpt_bufm_id_cnt} !== '0) begin
      miss_cnt++; $display("FAIL rst_rpt: rpt fields not all zero");
    end
    vec_cnt++;
    if ({report_valid, um.pktin_ready} !== 2'b01) begin
      miss_cnt++; $display("FAIL rst_flags: rv/ready got %b want 01", {report_valid, um.pktin_ready});
    end
    vec_cnt++;
    if ({rx_ok_cnt, rx_drop_cnt, rx_err_cnt} !== 96'd0) begin
      miss_cnt++; $display("FAIL rst_cnt: got %h want 0", {rx_ok_cnt, rx_drop_cnt, rx_err_cnt});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_good();
    make_frame(local_mac, 16'h1662, 64'h1122334455667788, 48'hABCDEF012345);
    send_words(0, 7, 1'b1, 1'b0, 1'b0);
    quiet();
    vec_cnt++;
    if (um.pktin_ready !== 1'b0) begin
      miss_cnt++; $display("FAIL good_ready_wait: got %b want 0", um.pktin_ready);
    end
    put_valid(1'b1);
    quiet();
    vec_cnt++;
    if (report_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL good_rv_early: got %b want 0", report_valid);
    end
    quiet();
    vec_cnt++;
    if (report_valid !== 1'b1) begin
      miss_cnt++; $display("FAIL good_rv: got %b want 1", report_valid);
    end
    vec_cnt++;
    if (rpt_esw_pktin_cnt !== 64'h1122334455667788) begin
      miss_cnt++; $display("FAIL good_esw_in: got %h want 1122334455667788", rpt_esw_pktin_cnt);
    end
    vec_cnt++;
    if (rpt_precision_time !== 48'hABCDEF012345) begin
      miss_cnt++; $display("FAIL good_ptime: got %h want abcdef012345", rpt_precision_time);
    end
    vec_cnt++;
    if ({rpt_lmid, rpt_direction, rpt_token_bucket_para, rpt_direct_mac_addr} !==
        {8'd1, 1'b1, 32'hCAFEBABE, 48'h665544332211}) begin
      miss_cnt++; $display("FAIL good_w2: got %h %b %h %h", rpt_lmid, rpt_direction,
                           rpt_token_bucket_para, rpt_direct_mac_addr);
    end
    vec_cnt++;
    if ({rpt_esw_pktout_cnt, rpt_eos_mdin_cnt, rpt_eos_mdout_cnt} !==
        {64'h0102030405060708, 64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A}) begin
      miss_cnt++; $display("FAIL good_w34: got %h %h %h", rpt_esw_pktout_cnt,
                           rpt_eos_mdin_cnt, rpt_eos_mdout_cnt);
    end
    vec_cnt++;
    if ({rpt_goe_pktin_cnt, rpt_goe_port0out_cnt, rpt_goe_port1out_cnt, rpt_goe_discard_cnt} !==
        {64'h1000000000000001, 64'h2000000000000002, 64'h3000000000000003,
         64'h4000000000000004}) begin
      miss_cnt++; $display("FAIL good_w56: got %h %h %h %h", rpt_goe_pktin_cnt,
                           rpt_goe_port0out_cnt, rpt_goe_port1out_cnt, rpt_goe_discard_cnt);
    end
    vec_cnt++;
    if ({rpt_q_used_cnt, rpt_bufm_id_cnt} !== {24'hABC123, 8'h77}) begin
      miss_cnt++; $display("FAIL good_w7: got %h %h want abc123 77", rpt_q_used_cnt,
                           rpt_bufm_id_cnt);
    end
    vec_cnt++;
    if (rx_ok_cnt !== 32'd1) begin
      miss_cnt++; $display("FAIL good_ok_cnt: got %0d want 1", rx_ok_cnt);
    end
    quiet();
    vec_cnt++;
    if ({report_valid, um.pktin_ready} !== 2'b01) begin
      miss_cnt++; $display("FAIL good_after: rv/ready got %b want 01", {report_valid, um.pktin_ready});
    end
  endtask

  task automatic test_bad_ethtype();
    int pulses = 0;
    make_frame(local_mac, 16'h0800, 64'hDEAD_BEEF_0000_0001, 48'h111111111111);
    send_words(0, 7, 1'b1, 1'b0, 1'b0);
    quiet();
    quiet();
    vec_cnt++;
    if (um.pktin_ready !== 1'b0) begin
      miss_cnt++; $display("FAIL drop_ready_wait: got %b want 0", um.pktin_ready);
    end
    put_valid(1'b1);
    for (int i = 0; i < 4; i++) begin
      quiet();
      if (report_valid === 1'b1) pulses++;
    end
    vec_cnt++;
    if (pulses !== 0) begin
      miss_cnt++; $display("FAIL drop_no_commit: got %0d pulses want 0", pulses);
    end
    vec_cnt++;
    if ({rx_drop_cnt, rx_err_cnt} !== {32'd1, 32'd0}) begin
      miss_cnt++; $display("FAIL drop_cnt: got drop %0d err %0d want 1 0", rx_drop_cnt, rx_err_cnt);
    end
    vec_cnt++;
    if ({rpt_esw_pktin_cnt, rpt_precision_time} !== {64'h1122334455667788, 48'hABCDEF012345}) begin
      miss_cnt++; $display("FAIL drop_keep: got %h %h", rpt_esw_pktin_cnt, rpt_precision_time);
    end
    vec_cnt++;
    if (um.pktin_ready !== 1'b1) begin
      miss_cnt++; $display("FAIL drop_ready_after: got %b want 1", um.pktin_ready);
    end
  endtask

  task automatic test_invalid();
    int pulses = 0;
    make_frame(local_mac, 16'h1662, 64'h9999_0000_9999_0000, 48'h222222222222);
    send_words(0, 7, 1'b1, 1'b0, 1'b0);
    put_valid(1'b0);
    for (int i = 0; i < 4; i++) begin
      quiet();
      if (report_valid === 1'b1) pulses++;
    end
    vec_cnt++;
    if (pulses !== 0) begin
      miss_cnt++; $display("FAIL inv_no_commit: got %0d pulses want 0", pulses);
    end
    vec_cnt++;
    if (rx_err_cnt !== 32'd1) begin
      miss_cnt++; $display("FAIL inv_err_cnt: got %0d want 1", rx_err_cnt);
    end
    vec_cnt++;
    if (rpt_esw_pktin_cnt !== 64'h1122334455667788) begin
      miss_cnt++; $display("FAIL inv_keep: got %h want 1122334455667788", rpt_esw_pktin_cnt);
    end
  endtask

  task automatic test_short();
    int pulses = 0;
    make_frame(local_mac, 16'h1662, 64'h5555_6666_7777_8888, 48'h333333333333);
    send_words(0, 5, 1'b1, 1'b0, 1'b0);
    put_valid(1'b1);
    for (int i = 0; i < 4; i++) begin
      quiet();
      if (report_valid === 1'b1) pulses++;
    end
    vec_cnt++;
    if ({pulses[3:0], rx_err_cnt} !== {4'd0, 32'd2}) begin
      miss_cnt++; $display("FAIL short_err: got pulses %0d err %0d want 0 2", pulses, rx_err_cnt);
    end
    make_frame(local_mac, 16'h1662, 64'h0F0E_0D0C_0B0A_0908, 48'h444444444444);
    send_words(0, 7, 1'b1, 1'b0, 1'b0);
    put_valid(1'b1);
    quiet();
    quiet();
    vec_cnt++;
    if ({report_valid, rpt_esw_pktin_cnt, rpt_precision_time} !==
        {1'b1, 64'h0F0E_0D0C_0B0A_0908, 48'h444444444444}) begin
      miss_cnt++; $display("FAIL short_next: rv %b esw %h pt %h", report_valid, rpt_esw_pktin_cnt,
                           rpt_precision_time);
    end
    vec_cnt++;
    if (rx_ok_cnt !== 32'd2) begin
      miss_cnt++; $display("FAIL short_ok_cnt: got %0d want 2", rx_ok_cnt);
    end
  endtask

  task automatic test_head_abort();
    make_frame(local_mac, 16'h1662, 64'hAAAA_AAAA_AAAA_AAAA, 48'h555555555555);
    send_words(0, 3, 1'b0, 1'b0, 1'b0);
    make_frame(local_mac, 16'h1662, 64'hBBBB_BBBB_BBBB_BBBB, 48'h666666666666);
    send_words(0, 7, 1'b1, 1'b0, 1'b0);
    put_valid(1'b1);
    quiet();
    quiet();
    vec_cnt++;
    if ({report_valid, rpt_esw_pktin_cnt, rpt_precision_time} !==
        {1'b1, 64'hBBBB_BBBB_BBBB_BBBB, 48'h666666666666}) begin
      miss_cnt++; $display("FAIL abort_commit: rv %b esw %h pt %h", report_valid,
                           rpt_esw_pktin_cnt, rpt_precision_time);
    end
    vec_cnt++;
    if ({rx_err_cnt, rx_ok_cnt} !== {32'd3, 32'd3}) begin
      miss_cnt++; $display("FAIL abort_cnt: got err %0d ok %0d want 3 3", rx_err_cnt, rx_ok_cnt);
    end
  endtask

  task automatic test_valid_on_tail();
    make_frame(local_mac, 16'h1662, 64'hC0C0_C0C0_C0C0_C0C0, 48'h777777777777);
    send_words(0, 7, 1'b1, 1'b1, 1'b1);
    quiet();
    vec_cnt++;
    if ({report_valid, um.pktin_ready} !== 2'b00) begin
      miss_cnt++; $display("FAIL vtail_early: rv/ready got %b want 00", {report_valid, um.pktin_ready});
    end
    quiet();
    vec_cnt++;
    if ({report_valid, rpt_esw_pktin_cnt, rx_ok_cnt} !== {1'b1, 64'hC0C0_C0C0_C0C0_C0C0, 32'd4}) begin
      miss_cnt++; $display("FAIL vtail_commit: rv %b esw %h ok %0d", report_valid,
                           rpt_esw_pktin_cnt, rx_ok_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    make_frame(local_mac, 16'h1662, 64'hD0D0_D0D0_D0D0_D0D0, 48'h888888888888);
    send_words(0, 5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    um.in_data_wr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({rpt_lmid, rpt_esw_pktin_cnt, rpt_precision_time, rpt_token_bucket_para} !== '0) begin
      miss_cnt++; $display("FAIL rmid_rpt: got %h %h %h", rpt_lmid, rpt_esw_pktin_cnt,
                           rpt_precision_time);
    end
    vec_cnt++;
    if ({rx_ok_cnt, rx_drop_cnt, rx_err_cnt, report_valid, um.pktin_ready} !== {96'd0, 2'b01}) begin
      miss_cnt++; $display("FAIL rmid_cnt: ok %0d drop %0d err %0d rv %b rdy %b", rx_ok_cnt,
                           rx_drop_cnt, rx_err_cnt, report_valid, um.pktin_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      quiet();
      if (report_valid === 1'b1) pulses++;
    end
    vec_cnt++;
    if (pulses !== 0) begin
      miss_cnt++; $display("FAIL rmid_no_pulse: got %0d pulses want 0", pulses);
    end
    make_frame(local_mac, 16'h1662, 64'hE1E2_E3E4_E5E6_E7E8, 48'h999999999999);
    send_words(0, 7, 1'b1, 1'b0, 1'b0);
    put_valid(1'b1);
    quiet();
    quiet();
    vec_cnt++;
    if ({report_valid, rpt_esw_pktin_cnt, rx_ok_cnt} !== {1'b1, 64'hE1E2_E3E4_E5E6_E7E8, 32'd1}) begin
      miss_cnt++; $display("FAIL rmid_recover: rv %b esw %h ok %0d", report_valid,
                           rpt_esw_pktin_cnt, rx_ok_cnt);
    end
  endtask

  initial begin
    um.in_data          = '0;
    um.in_data_wr       = 1'b0;
    um.in_data_valid    = 1'b0;
    um.in_data_valid_wr = 1'b0;
    test_reset();
    quiet();
    test_good();
    test_bad_ethtype();
    test_invalid();
    test_short();
    quiet();
    test_head_abort();
    quiet();
    test_valid_on_tail();
    quiet();
    test_reset_mid();
    quiet();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/lcm_report_rx.md
Name: lcm_report_rx

Overview:
- Receive end of the LCM beacon protocol. Sits on the controller-side datapath and consumes beacon report frames produced by a remote LCM, arriving as the 134-bit UM packet stream.
- Filters frames by MAC, EtherType, message type and LMID, then shadow-captures the report payload.
- Commits all report fields atomically to output registers only when the packet is confirmed good, and pulses report_valid.

Parameters:
ETH_TYPE, 16'h1662, EtherType of beacon frames.
RPT_TYPE, 8'h02, message-type code of a beacon report.
LMID, 8'd1, expected local-management ID; 8'hFF accepts any.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
in_data  in  134  UM word: [133:132] 01=head, 11=middle, 10=tail; [131:128] invalid-byte count; [127:0] data.
in_data_wr  in  1  in_data strobe.
in_data_valid  in  1  packet-good flag.
in_data_valid_wr  in  1  in_data_valid strobe, once per packet, on or after the tail cycle.
pktin_ready  out  1  may accept a new packet head.
in_local_mac_id  in  48  controller MAC, compared with the frame DMAC.
rpt_lmid  out  8  LMID of the last committed report.
rpt_direction  out  1  remote direction bit.
rpt_token_bucket_para  out  32  remote token-bucket parameter.
rpt_direct_mac_addr  out  48  remote direct MAC address.
rpt_esw_pktin_cnt, rpt_esw_pktout_cnt  out  64 each  remote ESW counters.
rpt_eos_mdin_cnt, rpt_eos_mdout_cnt  out  64 each  remote EOS counters.
rpt_goe_pktin_cnt, rpt_goe_port0out_cnt, rpt_goe_port1out_cnt, rpt_goe_discard_cnt  out  64 each  remote GOE counters.
rpt_precision_time  out  48  remote timestamp.
rpt_q_used_cnt  out  24  {q3,q2,q1,q0}, 6 bits each.
rpt_bufm_id_cnt  out  8  remote BUFM free-ID count.
report_valid  out  1  one-cycle pulse on commit.
rx_ok_cnt, rx_drop_cnt, rx_err_cnt  out  32 each  statistics counters.

Behaviour:
- Reset: all outputs 0; pktin_ready 1; FSM in IDLE; shadow registers cleared.
- Word layout, by index within the packet:
  - w0: metadata, ignored.
  - w1: [127:80] DMAC, [79:32] SMAC, [31:16] EtherType, [15:8] type, [7:0] LMID.
  - w2: [127] direction, [119:88] token_bucket, [87:40] direct_mac; other bits ignored.
  - w3: {esw_pktin, esw_pktout}.
  - w4: {eos_mdin, eos_mdout}.
  - w5: {goe_pktin, goe_port0out}.
  - w6: {goe_port1out, goe_discard}.
  - w7: [127:80] precision_time, [79:56] q_used, [55:48] bufm_id. w7 must carry the tail flag.
- FSM states:
  - IDLE: in_data_wr with head -> HDR. In_data_wr with a non-head word -> rx_err_cnt++, remain IDLE.
  - HDR: on w1, match = DMAC==in_local_mac_id AND EtherType==ETH_TYPE AND type==RPT_TYPE AND (LMID param==8'hFF or LMID field==LMID). Match -> PAYLOAD, latch lmid. Mismatch -> DISCARD.
  - PAYLOAD: word counter 2..7 loads the matching shadow field.
  - DISCARD: consumes words until tail, then -> WAIT_VLD.
  - Tail handling: tail on w7 -> WAIT_VLD with len_ok=1. Tail before w7, or no tail by w7 (long frame) -> len_ok=0. A long frame enters DISCARD until its tail.
  - Tail arriving at w0 or w1 -> WAIT_VLD with len_ok=0.
  - WAIT_VLD: pktin_ready=0. On in_data_valid_wr:
    - in_data_valid=1, matched, len_ok=1 -> COMMIT.
    - Discarded by filter -> rx_drop_cnt++ (even if valid=0).
    - Any other case -> rx_err_cnt++.
    - Then -> IDLE.
  - valid_wr coinciding with the tail cycle is evaluated as if it arrived in WAIT_VLD; pktin_ready stays 0 for that cycle.
  - COMMIT: copies all shadow fields to the rpt_* outputs in one cycle. report_valid=1 on the next cycle, coincident with new outputs visible; rx_ok_cnt++ -> IDLE.
  - Latency: tail/valid_wr to report_valid is 2 cycles.
- Rules:
  - rpt_* outputs change only in COMMIT; they are never partially updated.
  - A head seen in HDR, PAYLOAD or DISCARD (missing tail): rx_err_cnt++, abandon the current packet, restart in HDR with the new head. Its pending valid_wr is not awaited.
  - pktin_ready = 1 in IDLE, HDR, PAYLOAD and DISCARD; 0 in WAIT_VLD and COMMIT.
  - Statistics counters wrap modulo 2^32.
  - A valid_wr outside WAIT_VLD and outside the tail cycle is ignored.
  - Reset mid-packet: everything clears, no commit occurs.

Decomposition:
- Shared package lcm_pkg:
  - UM flag constants UM_HEAD=2'b01, UM_MID=2'b11, UM_TAIL=2'b10.
  - Word-index constants W_ETH=1 through W_LAST=7.
  - ETH_TYPE and beacon message-type codes (update=8'h01, report=8'h02).
  - Bit-field offset localparams, shared with lreport so both ends agree on the layout.
- One natural sub-module: lcm_rpt_shadow (shadow capture plus atomic commit register bank); the FSM stays in the top.

Test Plan:
- Good 8-word report, DMAC=in_local_mac_id, esw_pktin=64'h1122334455667788, precision_time=48'hABCDEF012345, valid=1 -> report_valid 2 cycles after valid_wr; fields exact; rx_ok_cnt=1.
- Same frame but EtherType 16'h0800 -> no commit, outputs unchanged, rx_drop_cnt=1, pktin_ready low until valid_wr.
- Matching frame with valid=0 -> outputs keep the previous report, rx_err_cnt=1.
- Short frame, tail at w5 -> rx_err_cnt=1, no commit; the next good frame commits normally.
- Head arriving at w4 of an in-flight packet -> rx_err_cnt=1; the new packet is parsed and commits with its own values.
- rst_n asserted at w6 of a good frame -> all rpt_* outputs 0, FSM IDLE, no report_valid pulse.
